// File: rtl/vga_timing_rx.sv
// VGA sink: measures line/frame timing, locks onto a stable mode and re-emits a framed pixel stream.
// Optional FRAME_CHECKSUM_EN adds frame_sum/frame_sum_vld (per-frame R+G+B sum of valid pixels).
module vga_timing_rx #(
    parameter int CW            = 12,
    parameter int STABLE_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Hsync,
    input  logic          Vsync,
    input  logic          Disp_activ,
    input  logic [7:0]    R_i,
    input  logic [7:0]    G_i,
    input  logic [7:0]    B_i,
    output logic [7:0]    R_o,
    output logic [7:0]    G_o,
    output logic [7:0]    B_o,
    output logic [CW-1:0] Xpos,
    output logic [CW-1:0] Ypos,
    output logic          pix_valid,
    output logic          sof,
    output logic          eol,
    output logic          locked,
    output logic          lock_err,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_active
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [31:0]   frame_sum,
    output logic          frame_sum_vld
`endif
);

    localparam int MW = (STABLE_FRAMES < 2) ? 1 : $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [MW-1:0] M_ONE = MW'(1);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_e;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + ONE;
    endfunction

    state_e        state_q, state_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          hs1_q, hs1p_q, vs1_q, vs1p_q, de1_q;
    logic [7:0]    r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;
    logic [CW-1:0] hcnt_q, hact_q, vcnt_q, vact_q, ltot_q, lact_q;
    logic [CW-1:0] vcnt_c, vact_c, ltot_c, lact_c;
    logic          hasl_q, hasa_q, var_q, hasl_c, hasa_c, var_c;
    logic [CW-1:0] cht_q, cha_q, cvt_q, cva_q;
    logic [CW-1:0] ht_q, ha_q, vt_q, va_q, xpos_q, ypos_q, xp, yp;
    logic          pv_q, sof_q, locked_q, err_q;
    logic          hrise, vrise, meas_diff, timeout, valid_d;
    logic          cand_ld, out_ld, err_d;

    assign hrise = hs1_q & ~hs1p_q;
    assign vrise = vs1_q & ~vs1p_q;

    // Fold the line closing this cycle (if any) into the frame totals, so a
    // coincident Hsync/Vsync rise counts the line before the frame closes.
    always_comb begin
        vcnt_c = vcnt_q;
        vact_c = vact_q;
        ltot_c = ltot_q;
        lact_c = lact_q;
        hasl_c = hasl_q;
        hasa_c = hasa_q;
        var_c  = var_q;
        if (hrise) begin
            vcnt_c = sat_inc(vcnt_q);
            ltot_c = hcnt_q;
            hasl_c = 1'b1;
            if (hasl_q && hcnt_q != ltot_q) var_c = 1'b1;
            if (hact_q != '0) begin
                vact_c = sat_inc(vact_q);
                lact_c = hact_q;
                hasa_c = 1'b1;
                if (hasa_q && hact_q != lact_q) var_c = 1'b1;
            end
        end
    end

    assign meas_diff = var_c || ltot_c != cht_q || lact_c != cha_q ||
                       vcnt_c != cvt_q || vact_c != cva_q;
    assign timeout   = (hcnt_q == CMAX && !hrise) || vcnt_q == CMAX;

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        cand_ld = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            SEARCH:  if (vrise) state_d = MEASURE;
            MEASURE: if (vrise) begin
                cand_ld = 1'b1;
                mcnt_d  = M_ONE;
                state_d = (STABLE_FRAMES <= 1) ? LOCKED : VERIFY;
            end
            VERIFY:  if (vrise) begin
                if (meas_diff) begin
                    cand_ld = 1'b1;
                    mcnt_d  = M_ONE;
                end else begin
                    mcnt_d = mcnt_q + M_ONE;
                    if (int'(mcnt_q) + 1 >= STABLE_FRAMES) state_d = LOCKED;
                end
            end
            LOCKED:  if (vrise && meas_diff) begin
                err_d   = 1'b1;
                cand_ld = 1'b1;
                mcnt_d  = M_ONE;
                state_d = VERIFY;
            end
            default: state_d = SEARCH;
        endcase
        if (state_q != SEARCH && timeout) begin
            state_d = SEARCH;
            mcnt_d  = '0;
            cand_ld = 1'b0;
            err_d   = (state_q == LOCKED);
        end
    end

    assign out_ld  = (state_d == LOCKED) && (state_q != LOCKED);
    assign valid_d = de1_q && (state_d == LOCKED);
    assign xp      = hrise ? '0 : hact_q;
    assign yp      = vrise ? '0 : vact_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {hs1_q, hs1p_q, vs1_q, vs1p_q, de1_q} <= '0;
            {r1_q, g1_q, b1_q, r2_q, g2_q, b2_q}  <= '0;
            {hcnt_q, hact_q, vcnt_q, vact_q, ltot_q, lact_q} <= '0;
            {hasl_q, hasa_q, var_q}               <= '0;
            {cht_q, cha_q, cvt_q, cva_q}          <= '0;
            {ht_q, ha_q, vt_q, va_q}              <= '0;
            {xpos_q, ypos_q}                      <= '0;
            {pv_q, sof_q, locked_q, err_q}        <= '0;
            state_q <= SEARCH;
            mcnt_q  <= '0;
        end else begin
            hs1_q  <= Hsync;
            hs1p_q <= hs1_q;
            vs1_q  <= Vsync;
            vs1p_q <= vs1_q;
            de1_q  <= Disp_activ;
            r1_q   <= R_i;
            g1_q   <= G_i;
            b1_q   <= B_i;
            // The rise cycle itself belongs to the new line, so it counts as 1.
            hcnt_q <= hrise ? ONE : sat_inc(hcnt_q);
            if (hrise)      hact_q <= de1_q ? ONE : '0;
            else if (de1_q) hact_q <= sat_inc(hact_q);
            if (vrise) begin
                {vcnt_q, vact_q, ltot_q, lact_q} <= '0;
                {hasl_q, hasa_q, var_q}          <= '0;
            end else begin
                {vcnt_q, vact_q, ltot_q, lact_q} <= {vcnt_c, vact_c, ltot_c, lact_c};
                {hasl_q, hasa_q, var_q}          <= {hasl_c, hasa_c, var_c};
            end
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            if (cand_ld) {cht_q, cha_q, cvt_q, cva_q} <= {ltot_c, lact_c, vcnt_c, vact_c};
            if (out_ld)  {ht_q, ha_q, vt_q, va_q}     <= {ltot_c, lact_c, vcnt_c, vact_c};
            r2_q     <= r1_q;
            g2_q     <= g1_q;
            b2_q     <= b1_q;
            xpos_q   <= xp;
            ypos_q   <= yp;
            pv_q     <= valid_d;
            sof_q    <= valid_d && xp == '0 && yp == '0;
            locked_q <= (state_d == LOCKED);
            err_q    <= err_d;
        end
    end

    assign R_o       = r2_q;
    assign G_o       = g2_q;
    assign B_o       = b2_q;
    assign Xpos      = xpos_q;
    assign Ypos      = ypos_q;
    assign pix_valid = pv_q;
    assign sof       = sof_q;
    assign eol       = pv_q & ~de1_q;
    assign locked    = locked_q;
    assign lock_err  = err_q;
    assign h_total   = ht_q;
    assign h_active  = ha_q;
    assign v_total   = vt_q;
    assign v_active  = va_q;

`ifdef FRAME_CHECKSUM_EN
    logic [31:0] acc_q, sum_q, px;
    logic        sum_vld_q;

    assign px = valid_d ? (32'(r1_q) + 32'(g1_q) + 32'(b1_q)) : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            acc_q     <= vrise ? px : acc_q + px;
            sum_vld_q <= vrise && (state_q == LOCKED);
            if (vrise) sum_q <= acc_q;
        end
    end

    assign frame_sum     = sum_q;
    assign frame_sum_vld = sum_vld_q;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Scoreboard bench for vga_timing_rx: driver pushes expected pixels, monitor pops on pix_valid.
module tb_vga_timing_rx;

    localparam int CW = 12;

    logic          clk = 1'b0, rst = 1'b0;
    logic          Hsync = 1'b0, Vsync = 1'b0, Disp_activ = 1'b0;
    logic [7:0]    R_i = '0, G_i = '0, B_i = '0;
    logic [7:0]    R_o, G_o, B_o;
    logic [CW-1:0] Xpos, Ypos, h_total, h_active, v_total, v_active;
    logic          pix_valid, sof, eol, locked, lock_err;
`ifdef FRAME_CHECKSUM_EN
    logic [31:0]   frame_sum;
    logic          frame_sum_vld;
`endif

    vga_timing_rx #(.CW(CW), .STABLE_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .Hsync(Hsync), .Vsync(Vsync), .Disp_activ(Disp_activ),
        .R_i(R_i), .G_i(G_i), .B_i(B_i), .R_o(R_o), .G_o(G_o), .B_o(B_o),
        .Xpos(Xpos), .Ypos(Ypos), .pix_valid(pix_valid), .sof(sof), .eol(eol),
        .locked(locked), .lock_err(lock_err),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active)
`ifdef FRAME_CHECKSUM_EN
        , .frame_sum(frame_sum), .frame_sum_vld(frame_sum_vld)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    r, g, b;
        logic [CW-1:0] x, y;
        logic          sof, eol;
    } pix_t;

    pix_t exp_q[$];
    int   stamp_q[$];
    int   n_cmp = 0, n_err = 0, cyc = 0, pv_cnt = 0, err_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: every output pixel must match the next queued expectation, 2 clk after it was driven.
    initial begin
        pix_t e, got;
        int   t;
        forever begin
            @(negedge clk);
            if (lock_err === 1'b1) err_hi++;
            if (pix_valid !== 1'b1 && (sof === 1'b1 || eol === 1'b1)) begin
                n_err++;
                $display("FAIL framing: sof=%0b eol=%0b while pix_valid=0", sof, eol);
            end
            if (pix_valid === 1'b1) begin
                pv_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pixel: unexpected pixel x=%0d y=%0d", Xpos, Ypos);
                end else begin
                    e = exp_q.pop_front();
                    t = stamp_q.pop_front();
                    got.r = R_o; got.g = G_o; got.b = B_o;
                    got.x = Xpos; got.y = Ypos; got.sof = sof; got.eol = eol;
                    if (got !== e || cyc - t != 2) begin
                        n_err++;
                        $display("FAIL pixel: got rgb=%h/%h/%h x=%0d y=%0d sof=%0b eol=%0b lat=%0d expected rgb=%h/%h/%h x=%0d y=%0d sof=%0b eol=%0b lat=2",
                                 got.r, got.g, got.b, got.x, got.y, got.sof, got.eol, cyc - t,
                                 e.r, e.g, e.b, e.x, e.y, e.sof, e.eol);
                    end
                end
            end
        end
    end

    // 30 lines of ht clocks; active window lines 5..24, columns 10..89 (80x20).
    task automatic send_frame(input int ht, input bit exp_on, input int rst_line);
        bit   on;
        logic de;
        pix_t e;
        on = exp_on;
        for (int k = 0; k < 30; k++) begin
            for (int c = 0; c < ht; c++) begin
                @(negedge clk);
                if (k == rst_line && c == 5) begin rst = 1'b0; on = 1'b0; end
                if (k == rst_line && c == 8) rst = 1'b1;
                de         = (k >= 5 && k < 25 && c >= 10 && c < 90);
                Hsync      = (c < 4);
                Vsync      = (k < 2);
                Disp_activ = de;
                R_i        = 8'(c - 10);
                G_i        = 8'(k - 5);
                B_i        = 8'(c + k);
                if (de && on) begin
                    e.r = 8'(c - 10); e.g = 8'(k - 5); e.b = 8'(c + k);
                    e.x = CW'(c - 10); e.y = CW'(k - 5);
                    e.sof = (c == 10 && k == 5);
                    e.eol = (c == 89);
                    exp_q.push_back(e);
                    stamp_q.push_back(cyc);
                end
                if (k == rst_line && c == 5) begin
                    #1;
                    chk("rstmid_locked", 32'(locked), 0);
                    chk("rstmid_pix_valid", 32'(pix_valid), 0);
                    chk("rstmid_Xpos", 32'(Xpos), 0);
                    chk("rstmid_h_total", 32'(h_total), 0);
                    chk("rstmid_R_o", 32'(R_o), 0);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            Hsync = 1'b0; Vsync = 1'b0; Disp_activ = 1'b0;
            R_i = '0; G_i = '0; B_i = '0;
        end
    endtask

    initial begin
        int p;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_lock_err", 32'(lock_err), 0);
        chk("rst_h_total", 32'(h_total), 0);
        chk("rst_Xpos", 32'(Xpos), 0);
        chk("rst_R_o", 32'(R_o), 0);
        @(negedge clk);
        rst = 1'b1;

        send_frame(100, 0, -1);
        send_frame(100, 0, -1);
        chk("locked_before_3rd_vsync", 32'(locked), 0);
        p = pv_cnt;
        send_frame(100, 1, -1);
        chk("locked_after_3rd_vsync", 32'(locked), 1);
        chk("h_total", 32'(h_total), 100);
        chk("h_active", 32'(h_active), 80);
        chk("v_total", 32'(v_total), 30);
        chk("v_active", 32'(v_active), 20);
        chk("pix_per_frame", 32'(pv_cnt - p), 1600);
        send_frame(100, 1, -1);

        // One frame of 101-clock lines: mismatch is seen at the following Vsync.
        send_frame(101, 1, -1);
        chk("no_err_during_bad_frame", 32'(err_hi), 0);
        send_frame(100, 0, -1);
        chk("lock_err_one_pulse", 32'(err_hi), 1);
        chk("unlocked_after_err", 32'(locked), 0);
        send_frame(100, 0, -1);
        chk("still_verifying", 32'(locked), 0);
        send_frame(100, 1, -1);
        chk("relocked", 32'(locked), 1);
        chk("h_total_relock", 32'(h_total), 100);

        p = pv_cnt;
        idle(4200);
        chk("timeout_unlocked", 32'(locked), 0);
        chk("timeout_lock_err", 32'(err_hi), 2);
        chk("timeout_no_pixels", 32'(pv_cnt - p), 0);
        chk("timeout_h_total_held", 32'(h_total), 100);

        send_frame(100, 0, -1);
        send_frame(100, 0, -1);
        send_frame(100, 1, -1);
        chk("relock_after_timeout", 32'(locked), 1);

        p = pv_cnt;
        send_frame(100, 1, 10);
        chk("pix_before_midreset", 32'(pv_cnt - p), 400);
        chk("unlocked_after_midreset", 32'(locked), 0);
        send_frame(100, 0, -1);
        send_frame(100, 0, -1);
        chk("not_locked_two_vsyncs", 32'(locked), 0);
        p = pv_cnt;
        send_frame(100, 1, -1);
        chk("relock_after_reset", 32'(locked), 1);
        chk("h_total_after_reset", 32'(h_total), 100);
        chk("v_active_after_reset", 32'(v_active), 20);
        chk("pix_after_reset", 32'(pv_cnt - p), 1600);

        idle(10);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("total_lock_err", 32'(err_hi), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
